// File: rtl/sobel_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sobel_pkg : frame geometry defaults, feeder state encoding, Sobel kernels |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package sobel_pkg;

    localparam int DEF_IMG_W  = 180;
    localparam int DEF_IMG_H  = 180;
    localparam int DEF_ADDR_W = 15;
    localparam int DEF_PIX_W  = 9;
    localparam int RAM_DW     = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_CAP  = 3'd4,
        ST_OUT  = 3'd5,
        ST_DONE = 3'd6
    } feeder_state_e;

    // Row-major 3x3 kernels; index = row*3 + col, row 0 is the top (r-1) row.
    localparam int KGX [0:8] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    localparam int KGY [0:8] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

    function automatic int kernel_gx(input int r, input int c);
        return KGX[r*3 + c];
    endfunction

    function automatic int kernel_gy(input int r, input int c);
        return KGY[r*3 + c];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_column_feeder_window_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | window_addr_gen : row/col/base counters and 3-row RAM address mux         |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module window_addr_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_i,
    input  logic              advance_i,
    input  logic [1:0]        phase_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        row_o,
    output logic [7:0]        col_o,
    output logic              last_col_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] ROW_STRIDE  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_STRIDE2 = ADDR_W'(2 * IMG_W);

    logic [7:0]        row_q, row_d;
    logic [7:0]        col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] row_off;

    // base tracks (row-1)*IMG_W incrementally so no multiplier is needed.
    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        base_d = base_q;
        if (init_i) begin
            row_d  = 8'd1;
            col_d  = '0;
            base_d = '0;
        end else if (advance_i) begin
            if (last_col_o) begin
                col_d  = '0;
                row_d  = row_q + 8'd1;
                base_d = base_q + ROW_STRIDE;
            end else begin
                col_d  = col_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q  <= '0;
            col_q  <= '0;
            base_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            base_q <= base_d;
        end
    end

    always_comb begin
        row_off = '0;
        case (phase_i)
            2'd1:    row_off = ROW_STRIDE;
            2'd2:    row_off = ROW_STRIDE2;
            default: row_off = '0;
        endcase
    end

    assign addr_o     = base_q + row_off + ADDR_W'(col_q);
    assign row_o      = row_q;
    assign col_o      = col_q;
    assign last_col_o = (col_q == 8'(IMG_W - 1));
    assign last_o     = last_col_o && (row_q == 8'(IMG_H - 2));

endmodule
`default_nettype wire

// File: rtl/sobel_column_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sobel_column_feeder : reads 3 vertically adjacent pixels per column and   |
// | presents them under valid/ready, centre rows 1..IMG_H-2.  rev 1.0         |
// +--------------------------------------------------------------------------+
module sobel_column_feeder
    import sobel_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PIX_W  = DEF_PIX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [RAM_DW-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  D1,
    output logic [PIX_W-1:0]  D2,
    output logic [PIX_W-1:0]  D3,
    output logic [7:0]        col,
    output logic [7:0]        row,
    output logic              last_col
);

    feeder_state_e     state_q, state_d;
    logic              gen_init, gen_advance;
    logic [1:0]        gen_phase;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_last_col, gen_last;
    logic [ADDR_W-1:0] addr_hold_q;
    logic [PIX_W-1:0]  d1_q, d2_q, d3_q;

    window_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .init_i     (gen_init),
        .advance_i  (gen_advance),
        .phase_i    (gen_phase),
        .addr_o     (gen_addr),
        .row_o      (row),
        .col_o      (col),
        .last_col_o (gen_last_col),
        .last_o     (gen_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gen_init    = 1'b0;
        gen_advance = 1'b0;
        gen_phase   = 2'd2;
        mem_rd_en   = 1'b0;
        out_valid   = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    gen_init = 1'b1;
                    state_d  = ST_RD0;
                end
            end
            ST_RD0: begin
                mem_rd_en = 1'b1;
                gen_phase = 2'd0;
                state_d   = ST_RD1;
            end
            ST_RD1: begin
                mem_rd_en = 1'b1;
                gen_phase = 2'd1;
                state_d   = ST_RD2;
            end
            ST_RD2: begin
                mem_rd_en = 1'b1;
                gen_phase = 2'd2;
                state_d   = ST_CAP;
            end
            ST_CAP: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (gen_last) begin
                        state_d = ST_DONE;
                    end else begin
                        gen_advance = 1'b1;
                        state_d     = ST_RD0;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM data lags the strobe by one cycle, so each capture state takes the
    // word requested by the state before it.
    always_ff @(posedge clk) begin
        if (rst) begin
            d1_q <= '0;
            d2_q <= '0;
            d3_q <= '0;
        end else begin
            case (state_q)
                ST_RD1:  d1_q <= PIX_W'(mem_rdata);
                ST_RD2:  d2_q <= PIX_W'(mem_rdata);
                ST_CAP:  d3_q <= PIX_W'(mem_rdata);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hold_q <= '0;
        end else if (mem_rd_en) begin
            addr_hold_q <= gen_addr;
        end
    end

    assign mem_addr = mem_rd_en ? gen_addr : addr_hold_q;
    assign busy     = (state_q != ST_IDLE);
    assign last_col = out_valid && gen_last_col;
    assign D1       = d1_q;
    assign D2       = d2_q;
    assign D3       = d3_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_column_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sobel_column_feeder : scoreboard bench, a 4x5 and a 20x14 instance     |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_sobel_column_feeder;

    localparam int N  = 2;
    localparam int WA = 4;
    localparam int HA = 5;
    localparam int WB = 20;
    localparam int HB = 14;

    typedef struct packed {
        logic [8:0] d1;
        logic [8:0] d2;
        logic [8:0] d3;
        logic [7:0] row;
        logic [7:0] col;
        logic       lc;
    } trip_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start     [N];
    logic        out_ready [N];
    logic        busy      [N];
    logic        done      [N];
    logic        rd_en     [N];
    logic        valid     [N];
    logic        last_col  [N];
    logic [14:0] addr      [N];
    logic [7:0]  rdata     [N];
    logic [7:0]  col       [N];
    logic [7:0]  row       [N];
    logic [8:0]  d1        [N];
    logic [8:0]  d2        [N];
    logic [8:0]  d3        [N];

    trip_t       eq[$];
    logic [14:0] aq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          hs_cnt      [N] = '{0, 0};
    int          done_cnt    [N] = '{0, 0};
    int          last_hs_cyc [N] = '{0, 0};

    sobel_column_feeder #(.IMG_W(WA), .IMG_H(HA), .ADDR_W(15), .PIX_W(9)) u_dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .mem_rd_en(rd_en[0]), .mem_addr(addr[0]), .mem_rdata(rdata[0]),
        .out_valid(valid[0]), .out_ready(out_ready[0]),
        .D1(d1[0]), .D2(d2[0]), .D3(d3[0]), .col(col[0]), .row(row[0]), .last_col(last_col[0])
    );

    sobel_column_feeder #(.IMG_W(WB), .IMG_H(HB), .ADDR_W(15), .PIX_W(9)) u_dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .mem_rd_en(rd_en[1]), .mem_addr(addr[1]), .mem_rdata(rdata[1]),
        .out_valid(valid[1]), .out_ready(out_ready[1]),
        .D1(d1[1]), .D2(d2[1]), .D3(d3[1]), .col(col[1]), .row(row[1]), .last_col(last_col[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM image: pixel = address mod 256, one-cycle read latency.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rd_en[i]) rdata[i] <= addr[i][7:0];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail_msg(input string nm, input string what);
        total++;
        bad++;
        $display("FAIL %s: %s", nm, what);
    endtask

    task automatic push_frame(input int w, input int h);
        trip_t t;
        for (int r = 1; r <= h - 2; r++) begin
            for (int c = 0; c < w; c++) begin
                for (int k = 0; k < 3; k++) aq.push_back(15'((r - 1 + k) * w + c));
                t.d1  = 9'(((r - 1) * w + c) % 256);
                t.d2  = 9'((r * w + c) % 256);
                t.d3  = 9'(((r + 1) * w + c) % 256);
                t.row = 8'(r);
                t.col = 8'(c);
                t.lc  = (c == w - 1);
                eq.push_back(t);
            end
        end
    endtask

    task automatic wait_done(input int i, input int n0, input int budget);
        int k;
        k = 0;
        while (done_cnt[i] == n0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (done_cnt[i] == n0) fail_msg("done_timeout", "got no done pulse, expected one");
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        @(posedge clk);
        #1;
        start[i] = 1'b0;
    endtask

    // Monitor: pops expected reads and triples as the DUTs present them.
    always @(negedge clk) begin
        trip_t t;
        for (int i = 0; i < N; i++) begin
            if (rd_en[i]) begin
                if (aq.size() == 0) fail_msg("addr_unexp", "got a read, expected none");
                else chk("mem_addr", 64'(addr[i]), 64'(aq.pop_front()));
            end
            if (valid[i] && out_ready[i]) begin
                hs_cnt[i]++;
                last_hs_cyc[i] = cyc;
                if (eq.size() == 0) begin
                    fail_msg("triple_unexp", "got a triple, expected none");
                end else begin
                    t = eq.pop_front();
                    chk("D1", 64'(d1[i]), 64'(t.d1));
                    chk("D2", 64'(d2[i]), 64'(t.d2));
                    chk("D3", 64'(d3[i]), 64'(t.d3));
                    chk("row", 64'(row[i]), 64'(t.row));
                    chk("col", 64'(col[i]), 64'(t.col));
                    chk("last_col", 64'(last_col[i]), 64'(t.lc));
                end
            end
            if (done[i]) begin
                done_cnt[i]++;
                chk("done_after_hs", 64'(cyc), 64'(last_hs_cyc[i] + 1));
            end
        end
    end

    initial begin
        int h0, n0, k;
        for (int i = 0; i < N; i++) begin
            start[i]     = 1'b0;
            out_ready[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(valid[0]), 0);
        chk("rst_busy", 64'(busy[0]), 0);
        chk("rst_done", 64'(done[0]), 0);
        chk("rst_rd_en", 64'(rd_en[0]), 0);
        chk("rst_addr", 64'(addr[0]), 0);
        chk("rst_D1", 64'(d1[0]), 0);
        chk("rst_D3", 64'(d3[0]), 0);
        chk("rst_row", 64'(row[0]), 0);
        chk("rst_col", 64'(col[0]), 0);
        chk("rst_b_busy", 64'(busy[1]), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Frame 1 on 4x5: latency, backpressure, ignored mid-frame start.
        push_frame(WA, HA);
        h0 = hs_cnt[0];
        n0 = done_cnt[0];
        pulse_start(0);
        chk("lat_busy", 64'(busy[0]), 1);
        chk("lat_rd_t1", 64'(rd_en[0]), 1);
        @(posedge clk); #1;
        chk("lat_rd_t2", 64'(rd_en[0]), 1);
        @(posedge clk); #1;
        chk("lat_rd_t3", 64'(rd_en[0]), 1);
        @(posedge clk); #1;
        chk("lat_rd_t4", 64'(rd_en[0]), 0);
        chk("lat_valid_t4", 64'(valid[0]), 0);
        @(posedge clk); #1;
        chk("lat_valid_t5", 64'(valid[0]), 1);
        for (int s = 0; s < 7; s++) begin
            chk("stall_valid", 64'(valid[0]), 1);
            chk("stall_D1", 64'(d1[0]), 0);
            chk("stall_D2", 64'(d2[0]), 4);
            chk("stall_D3", 64'(d3[0]), 8);
            chk("stall_rd_en", 64'(rd_en[0]), 0);
            @(posedge clk); #1;
        end
        out_ready[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        pulse_start(0);
        wait_done(0, n0, 200);
        repeat (10) @(posedge clk);
        #1;
        chk("a1_triples", 64'(hs_cnt[0] - h0), 12);
        chk("a1_done_cnt", 64'(done_cnt[0] - n0), 1);
        chk("a1_eq_empty", 64'(eq.size()), 0);
        chk("a1_aq_empty", 64'(aq.size()), 0);
        chk("a1_idle_busy", 64'(busy[0]), 0);

        // Frame 2: reset while the first triple is stalled in OUT.
        out_ready[0] = 1'b0;
        push_frame(WA, HA);
        n0 = done_cnt[0];
        pulse_start(0);
        k = 0;
        while (!valid[0] && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("abort_reach_out", 64'(valid[0]), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_valid", 64'(valid[0]), 0);
        chk("abort_busy", 64'(busy[0]), 0);
        chk("abort_D1", 64'(d1[0]), 0);
        chk("abort_D2", 64'(d2[0]), 0);
        chk("abort_D3", 64'(d3[0]), 0);
        chk("abort_done", 64'(done[0]), 0);
        rst = 1'b0;
        eq.delete();
        aq.delete();
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt[0] - n0), 0);

        // Frame 3: restart after abort from address 0.
        push_frame(WA, HA);
        h0 = hs_cnt[0];
        n0 = done_cnt[0];
        out_ready[0] = 1'b1;
        pulse_start(0);
        wait_done(0, n0, 200);
        repeat (3) @(posedge clk);
        #1;
        chk("a3_triples", 64'(hs_cnt[0] - h0), 12);
        chk("a3_done_cnt", 64'(done_cnt[0] - n0), 1);

        // Frame on 20x14: address wrap past 256 and long row walk.
        push_frame(WB, HB);
        h0 = hs_cnt[1];
        n0 = done_cnt[1];
        out_ready[1] = 1'b1;
        pulse_start(1);
        wait_done(1, n0, 2000);
        repeat (3) @(posedge clk);
        #1;
        chk("b_triples", 64'(hs_cnt[1] - h0), 240);
        chk("b_done_cnt", 64'(done_cnt[1] - n0), 1);
        chk("b_eq_empty", 64'(eq.size()), 0);
        chk("b_aq_empty", 64'(aq.size()), 0);
        chk("b_last_D3", 64'(d3[1]), 23);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
